// File: rtl/im_loader_pkg.sv
// -----------------------------------------------------------------------------
// im_loader_pkg
// Shared constants for the instruction-memory loader and the instruction
// memory itself: address width, bytes per word and the loader FSM encoding.
// ST_CHECK is only reached when the loader is built with IM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package im_loader_pkg;

  localparam int IM_ADDR_W  = 10;
  localparam int WORD_BYTES = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;

endpackage

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
// Streams a boot image into instruction memory one byte at a time, packs the
// bytes big-endian into 32-bit words and issues one write per word while
// holding the CPU fetch path frozen.
//
// Optional feature (define IM_LOADER_CHECKSUM_EN): keeps a running XOR of the
// image bytes and accepts one trailing checksum byte; a mismatch raises err
// and keeps the CPU held.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   start      : one-cycle request to begin a load (honoured in IDLE/DONE)
//   byte_valid : byte_data valid this cycle
//   byte_data  : image byte stream, big-endian within each word
//   byte_last  : final image byte (qualified by byte_valid)
//   byte_ready : loader accepts a byte this cycle
//   we         : instruction-memory write strobe (one cycle per word)
//   waddr      : word-aligned byte address of the write
//   wdata      : assembled instruction word
//   cpu_hold   : freezes the PC/fetch path while high
//   done       : load finished (level)
//   err        : load failed (level; constant 0 without the checksum)
// -----------------------------------------------------------------------------
module im_loader
  import im_loader_pkg::*;
#(
  parameter int WORDS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 byte_last,
  output logic                 byte_ready,
  output logic                 we,
  output logic [IM_ADDR_W-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  // Wide enough to hold WORDS itself so the index never wraps.
  localparam int IDX_W = $clog2(WORDS + 1);

  logic [2:0]       state;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic             last_seen;
  logic             accept;
  logic             load_end;

  // First byte of a word clears the rest, so a short final word is zero-filled.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w = {b, 24'h000000};
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  assign byte_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign err        = err_q;
`else
  assign byte_ready = (state == ST_LOAD);
  assign err        = 1'b0;
`endif

  assign accept   = byte_valid && byte_ready;
  assign we       = (state == ST_WRITE);
  assign waddr    = IM_ADDR_W'(word_idx) << 2;
  assign load_end = last_seen || (word_idx == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      byte_cnt  <= '0;
      last_seen <= 1'b0;
      wdata     <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            word_idx  <= '0;
            byte_cnt  <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
            csum      <= '0;
            err_q     <= 1'b0;
`endif
            state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            wdata <= put_byte(wdata, byte_cnt, byte_data);
`ifdef IM_LOADER_CHECKSUM_EN
            csum  <= csum ^ byte_data;
`endif
            if (byte_last || (byte_cnt == 2'(WORD_BYTES - 1))) begin
              byte_cnt  <= '0;
              last_seen <= byte_last;
              state     <= ST_WRITE;
            end else begin
              byte_cnt  <= byte_cnt + 2'd1;
            end
          end
        end

        // we is high for this single cycle; the index moves on afterwards.
        ST_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (load_end) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state    <= ST_CHECK;
`else
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= ST_DONE;
`endif
          end else begin
            state <= ST_LOAD;
          end
        end

`ifdef IM_LOADER_CHECKSUM_EN
        // A bad checksum leaves the CPU held so it never runs a corrupt image.
        ST_CHECK: begin
          if (accept) begin
            err_q    <= (byte_data != csum);
            cpu_hold <= (byte_data != csum);
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;
  import im_loader_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 byte_valid = 1'b0;
  logic [7:0]           byte_data = 8'h00;
  logic                 byte_last = 1'b0;
  logic                 byte_ready;
  logic                 we;
  logic [IM_ADDR_W-1:0] waddr;
  logic [31:0]          wdata;
  logic                 cpu_hold;
  logic                 done;
  logic                 err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [7:0] tb_xor = 8'h00;

  logic [IM_ADDR_W-1:0] wr_addr[$];
  logic [31:0]          wr_data[$];
  int                   wr_cyc[$];

  im_loader #(.WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tb_xor = 8'h00;
  endtask

  task automatic pulse_start_only();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      last_acc   = cyc;
      tb_xor     = tb_xor ^ b;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end
  endtask

  // With the checksum compiled in, a load ends with the correct checksum byte.
  task automatic finish_load();
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(tb_xor, 1'b0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int c4;
    int c8;

    // Reset state
    #12;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we",    32'(we),         32'd0);
    check("rst_waddr", 32'(waddr),      32'd0);
    check("rst_wdata", wdata,           32'd0);
    check("rst_hold",  32'(cpu_hold),   32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(err),        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single word image
    clear_log();
    do_start();
    @(negedge clk);
    check("t1_hold_load", 32'(cpu_hold), 32'd1);
    check("t1_ready",     32'(byte_ready), 32'd1);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b1);
    finish_load();
    wait_done("t1_done");
    check("t1_nwr",  32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("t1_addr", 32'(wr_addr[0]), 32'h000);
      check("t1_data", wr_data[0],      32'h20080005);
    end
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_err",  32'(err),      32'd0);

    // Two full words, write latency
    clear_log();
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hA0 + 8'(i), i == 7);
      if (i == 3) c4 = last_acc;
      if (i == 7) c8 = last_acc;
    end
    finish_load();
    wait_done("t2_done");
    check("t2_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      check("t2_addr0", 32'(wr_addr[0]), 32'h000);
      check("t2_data0", wr_data[0],      32'hA0A1A2A3);
      check("t2_lat0",  32'(wr_cyc[0]),  32'(c4));
      check("t2_addr1", 32'(wr_addr[1]), 32'h004);
      check("t2_data1", wr_data[1],      32'hA4A5A6A7);
      check("t2_lat1",  32'(wr_cyc[1]),  32'(c8));
    end

    // Short final word is zero-filled
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), i == 5);
    finish_load();
    wait_done("t3_done");
    check("t3_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      check("t3_data0", wr_data[0],      32'h11121314);
      check("t3_addr1", 32'(wr_addr[1]), 32'h004);
      check("t3_data1", wr_data[1],      32'h15160000);
    end

    // start during LOAD is ignored
    clear_log();
    do_start();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    pulse_start_only();
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    finish_load();
    wait_done("t4_done");
    check("t4_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("t4_addr", 32'(wr_addr[0]), 32'h000);
      check("t4_data", wr_data[0],      32'hDEADBEEF);
    end

    // Full capacity without byte_last
    clear_log();
    do_start();
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b0);
    finish_load();
    wait_done("t5_done");
    check("t5_nwr", 32'(wr_addr.size()), 32'd256);
    if (wr_addr.size() == 256) begin
      check("t5_addr0",  32'(wr_addr[0]),   32'h000);
      check("t5_data0",  wr_data[0],        32'h00010203);
      check("t5_addrN",  32'(wr_addr[255]), 32'h3FC);
      check("t5_dataN",  wr_data[255],      32'hFCFDFEFF);
    end
    repeat (3) @(negedge clk);
    check("t5_ready_after", 32'(byte_ready), 32'd0);
    check("t5_hold",        32'(cpu_hold),   32'd0);

    // Reset mid-word abandons the partial word
    clear_log();
    do_start();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready", 32'(byte_ready), 32'd0);
    check("t6_we",    32'(we),         32'd0);
    check("t6_waddr", 32'(waddr),      32'd0);
    check("t6_wdata", wdata,           32'd0);
    check("t6_hold",  32'(cpu_hold),   32'd0);
    check("t6_done",  32'(done),       32'd0);
    check("t6_err",   32'(err),        32'd0);
    repeat (2) @(negedge clk);
    check("t6_nwr", 32'(wr_addr.size()), 32'd0);
    rst = 1'b1;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h45, 1'b0);
    send_byte(8'h67, 1'b1);
    finish_load();
    wait_done("t6b_done");
    check("t6b_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("t6b_addr", 32'(wr_addr[0]), 32'h000);
      check("t6b_data", wr_data[0],      32'h01234567);
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // Checksum good then bad
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    send_byte(8'h04, 1'b0);
    wait_done("t7_done_ok");
    check("t7_err_ok",  32'(err),      32'd0);
    check("t7_hold_ok", 32'(cpu_hold), 32'd0);
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b0);
    wait_done("t7_done_bad");
    check("t7_err_bad",  32'(err),      32'd1);
    check("t7_hold_bad", 32'(cpu_hold), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
